// File: rtl/lcd_fill_rect.sv
// Rectangle fill sequencer for an SPI-attached LCD: emits the column/row window
// header and then the pixel colour bytes, one byte per writer handshake.
module lcd_fill_rect #(
    parameter logic [8:0] X_OFS = 9'd0,
    parameter logic [8:0] Y_OFS = 9'd0
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        wr_done,
    input  logic        fill_flag,
    input  logic [8:0]  start_x,
    input  logic [8:0]  end_x,
    input  logic [8:0]  start_y,
    input  logic [8:0]  end_y,
    input  logic [15:0] fill_color,
    output logic [8:0]  fill_data,
    output logic        en_write_fill,
    output logic        fill_busy,
    output logic        fill_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        PIX_HI = 3'd2,
        PIX_LO = 3'd3,
        WAIT   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state_r, state_s;
    state_t      last_emit_r, last_emit_s;
    logic [3:0]  hdr_idx_r, hdr_idx_s;
    logic [8:0]  sx_r, ex_r, sy_r, ey_r;
    logic [8:0]  sx_s, ex_s, sy_s, ey_s;
    logic [8:0]  col_r, row_r, col_s, row_s;
    logic [15:0] color_r, color_s;
    logic [8:0]  data_r, data_s;
    logic        en_r, en_s, busy_r, busy_s, done_r, done_s;
    logic        inverted_s, last_pix_s, hdr_last_s, emit_s;
    logic [8:0]  xs_s, xe_s, ys_s, ye_s;

    // Header byte table; bit 8 marks a data byte, clear for the three commands.
    function automatic logic [8:0] hdr_byte(input logic [3:0] idx,
                                            input logic [8:0] xs, input logic [8:0] xe,
                                            input logic [8:0] ys, input logic [8:0] ye);
        case (idx)
            4'd0:    hdr_byte = 9'h02A;
            4'd1:    hdr_byte = {1'b1, 7'd0, xs[8]};
            4'd2:    hdr_byte = {1'b1, xs[7:0]};
            4'd3:    hdr_byte = {1'b1, 7'd0, xe[8]};
            4'd4:    hdr_byte = {1'b1, xe[7:0]};
            4'd5:    hdr_byte = 9'h02B;
            4'd6:    hdr_byte = {1'b1, 7'd0, ys[8]};
            4'd7:    hdr_byte = {1'b1, ys[7:0]};
            4'd8:    hdr_byte = {1'b1, 7'd0, ye[8]};
            4'd9:    hdr_byte = {1'b1, ye[7:0]};
            4'd10:   hdr_byte = 9'h02C;
            default: hdr_byte = 9'h000;
        endcase
    endfunction

    assign xs_s       = sx_r + X_OFS;
    assign xe_s       = ex_r + X_OFS;
    assign ys_s       = sy_r + Y_OFS;
    assign ye_s       = ey_r + Y_OFS;
    assign inverted_s = (end_x < start_x) || (end_y < start_y);
    assign last_pix_s = (col_r == ex_r) && (row_r == ey_r);
    assign hdr_last_s = (hdr_idx_r == 4'd10);

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; each emitting state lasts one cycle, then waits for the writer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (fill_flag) begin
                    state_s = inverted_s ? DONE : HDR;
                end else begin
                    state_s = IDLE;
                end
            end
            HDR, PIX_HI, PIX_LO: state_s = WAIT;
            WAIT: begin
                if (wr_done) begin
                    case (last_emit_r)
                        HDR:     state_s = hdr_last_s ? PIX_HI : HDR;
                        PIX_HI:  state_s = PIX_LO;
                        PIX_LO:  state_s = last_pix_s ? DONE : PIX_HI;
                        default: state_s = IDLE;
                    endcase
                end else begin
                    state_s = WAIT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath and output next values; outputs are registered from these.
    always_comb begin
        sx_s      = sx_r;
        ex_s      = ex_r;
        sy_s      = sy_r;
        ey_s      = ey_r;
        color_s   = color_r;
        col_s     = col_r;
        row_s     = row_r;
        hdr_idx_s = hdr_idx_r;
        busy_s    = busy_r;
        case (state_r)
            IDLE: begin
                if (fill_flag) begin
                    sx_s      = start_x;
                    ex_s      = end_x;
                    sy_s      = start_y;
                    ey_s      = end_y;
                    color_s   = fill_color;
                    col_s     = start_x;
                    row_s     = start_y;
                    hdr_idx_s = 4'd0;
                    busy_s    = 1'b1;
                end else begin
                    busy_s    = 1'b0;
                end
            end
            WAIT: begin
                if (wr_done && (last_emit_r == HDR) && !hdr_last_s) begin
                    hdr_idx_s = hdr_idx_r + 4'd1;
                end else if (wr_done && (last_emit_r == PIX_LO) && !last_pix_s) begin
                    // Column innermost; row only advances after the last column.
                    if (col_r == ex_r) begin
                        col_s = sx_r;
                        row_s = row_r + 9'd1;
                    end else begin
                        col_s = col_r + 9'd1;
                    end
                end else begin
                    hdr_idx_s = hdr_idx_r;
                end
            end
            DONE:    busy_s = 1'b0;
            default: busy_s = busy_r;
        endcase
        emit_s      = (state_s == HDR) || (state_s == PIX_HI) || (state_s == PIX_LO);
        en_s        = emit_s;
        done_s      = (state_r == DONE);
        last_emit_s = emit_s ? state_s : last_emit_r;
        case (state_s)
            HDR:     data_s = hdr_byte(hdr_idx_s, xs_s, xe_s, ys_s, ye_s);
            PIX_HI:  data_s = {1'b1, color_r[15:8]};
            PIX_LO:  data_s = {1'b1, color_r[7:0]};
            default: data_s = data_r;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_emit_r <= IDLE;
            hdr_idx_r   <= 4'd0;
            sx_r        <= 9'd0;
            ex_r        <= 9'd0;
            sy_r        <= 9'd0;
            ey_r        <= 9'd0;
            col_r       <= 9'd0;
            row_r       <= 9'd0;
            color_r     <= 16'd0;
            data_r      <= 9'h000;
            en_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            last_emit_r <= last_emit_s;
            hdr_idx_r   <= hdr_idx_s;
            sx_r        <= sx_s;
            ex_r        <= ex_s;
            sy_r        <= sy_s;
            ey_r        <= ey_s;
            col_r       <= col_s;
            row_r       <= row_s;
            color_r     <= color_s;
            data_r      <= data_s;
            en_r        <= en_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign fill_data     = data_r;
    assign en_write_fill = en_r;
    assign fill_busy     = busy_r;
    assign fill_done     = done_r;

endmodule

// File: tb/tb_lcd_fill_rect.sv
// Directed bench for lcd_fill_rect: byte streams, timing, boundaries, busy and reset cases.
module tb_lcd_fill_rect;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        wr_done;
    logic        fill_flag;
    logic [8:0]  start_x, end_x, start_y, end_y;
    logic [15:0] fill_color;
    logic [8:0]  fill_data, fill_data1;
    logic        en_write_fill, en1, fill_busy, busy1, fill_done, done1;

    int checks = 0, errors = 0;
    int run_step, strobes, done_cnt, done_step, first_strobe_step;
    int busy_hi, busy_gap, resp_cnt, resp_delay, desync = 0, bad_pix;
    int inj_step = -1, spur_step = -1;
    bit track = 1'b0;
    logic [8:0] q0[$], q1[$], exp_q[$];

    always #5 sys_clk = ~sys_clk;

    lcd_fill_rect dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_done(wr_done), .fill_flag(fill_flag),
        .start_x(start_x), .end_x(end_x), .start_y(start_y), .end_y(end_y),
        .fill_color(fill_color), .fill_data(fill_data), .en_write_fill(en_write_fill),
        .fill_busy(fill_busy), .fill_done(fill_done)
    );

    lcd_fill_rect #(.X_OFS(9'd2), .Y_OFS(9'd1)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_done(wr_done), .fill_flag(fill_flag),
        .start_x(start_x), .end_x(end_x), .start_y(start_y), .end_y(end_y),
        .fill_color(fill_color), .fill_data(fill_data1), .en_write_fill(en1),
        .fill_busy(busy1), .fill_done(done1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample outputs on the falling edge, then play the SPI writer.
    task automatic step();
        @(negedge sys_clk);
        run_step++;
        if (en_write_fill === 1'b1) begin
            q0.push_back(fill_data);
            q1.push_back(fill_data1);
            strobes++;
            if (first_strobe_step < 0) first_strobe_step = run_step;
        end
        if (track && fill_busy === 1'b1) busy_hi++;
        if (track && fill_busy !== 1'b1 && fill_done !== 1'b1) busy_gap++;
        if (fill_done === 1'b1) begin
            done_cnt++;
            if (done_step < 0) done_step = run_step;
            track = 1'b0;
        end
        if (en1 !== en_write_fill || busy1 !== fill_busy || done1 !== fill_done) desync++;
        wr_done = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) wr_done = 1'b1;
        end
        if (en_write_fill === 1'b1) resp_cnt = resp_delay;
        if (run_step == spur_step) wr_done = 1'b1;
        fill_flag = (run_step == inj_step);
    endtask

    task automatic run_fill(input logic [8:0] sx, input logic [8:0] ex, input logic [8:0] sy,
                            input logic [8:0] ey, input logic [15:0] col, input int d,
                            input int stop_at, input int budget);
        q0.delete(); q1.delete();
        strobes = 0; done_cnt = 0; done_step = -1; first_strobe_step = -1;
        busy_hi = 0; busy_gap = 0; resp_cnt = 0; resp_delay = d; run_step = 0;
        start_x = sx; end_x = ex; start_y = sy; end_y = ey; fill_color = col;
        fill_flag = 1'b1;
        track = 1'b1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_cnt > 0) break;
            if (stop_at > 0 && strobes >= stop_at) break;
        end
    endtask

    task automatic cmp_stream(input string tag, input logic [8:0] got[$], input int n);
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s[%0d]", tag, i),
                     (i < got.size()) ? {23'd0, got[i]} : 32'hDEAD, {23'd0, exp_q[i]});
        end
    endtask

    task automatic load_1x1();
        exp_q = '{9'h02A, 9'h100, 9'h105, 9'h100, 9'h105, 9'h02B, 9'h100, 9'h107,
                  9'h100, 9'h107, 9'h02C, 9'h1F8, 9'h100};
    endtask

    initial begin
        sys_rst_n = 1'b0; wr_done = 1'b0; fill_flag = 1'b0;
        start_x = 9'd0; end_x = 9'd0; start_y = 9'd0; end_y = 9'd0; fill_color = 16'd0;
        resp_cnt = 0; resp_delay = 1; run_step = 0; strobes = 0; done_cnt = 0;
        repeat (3) step();
        check_eq("rst_data", {23'd0, fill_data}, 32'h000);
        check_eq("rst_en", {31'd0, en_write_fill}, 32'd0);
        check_eq("rst_busy", {31'd0, fill_busy}, 32'd0);
        check_eq("rst_done", {31'd0, fill_done}, 32'd0);
        sys_rst_n = 1'b1;
        step();

        // Spurious wr_done while idle must not produce a byte.
        strobes = 0;
        spur_step = run_step + 1;
        repeat (3) step();
        spur_step = -1;
        check_eq("idle_spur_strobes", strobes, 0);

        // 1x1 fill, writer answers 3 cycles after each strobe.
        run_fill(9'd5, 9'd5, 9'd7, 9'd7, 16'hF800, 3, 0, 200);
        load_1x1();
        cmp_stream("one", q0, 13);
        check_eq("one_strobes", strobes, 13);
        check_eq("one_first_strobe", first_strobe_step, 1);
        check_eq("one_done_step", done_step, 54);
        check_eq("one_busy_cycles", busy_hi, 53);
        repeat (3) step();
        check_eq("one_done_pulses", done_cnt, 1);
        check_eq("one_hold_data", {23'd0, fill_data}, 32'h100);

        // Offsets on dut1, 256-wide single row, fastest writer.
        run_fill(9'd0, 9'd255, 9'd0, 9'd0, 16'hA55A, 1, 0, 3000);
        exp_q = '{9'h02A, 9'h100, 9'h102, 9'h101, 9'h101, 9'h02B, 9'h100, 9'h101,
                  9'h100, 9'h101, 9'h02C};
        cmp_stream("ofs1", q1, 11);
        exp_q = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h1FF, 9'h02B, 9'h100, 9'h100,
                  9'h100, 9'h100, 9'h02C};
        cmp_stream("ofs0", q0, 11);
        check_eq("ofs_strobes", strobes, 523);
        check_eq("ofs_done_step", done_step, 1048);
        check_eq("ofs_last_hi", (q0.size() > 522) ? {23'd0, q0[521]} : 32'hDEAD, 32'h1A5);
        check_eq("ofs_last_lo", (q0.size() > 522) ? {23'd0, q0[522]} : 32'hDEAD, 32'h15A);

        // Inverted window, then an immediate new request.
        run_fill(9'd10, 9'd9, 9'd0, 9'd0, 16'h1111, 1, 0, 50);
        check_eq("inv_strobes", strobes, 0);
        check_eq("inv_done_step", done_step, 2);
        check_eq("inv_busy_cycles", busy_hi, 1);
        check_eq("inv_done_pulses", done_cnt, 1);

        // Top corner of the coordinate space: counters reach 511 without wrapping.
        run_fill(9'd510, 9'd511, 9'd510, 9'd511, 16'h07E0, 1, 0, 200);
        exp_q = '{9'h02A, 9'h101, 9'h1FE, 9'h101, 9'h1FF, 9'h02B, 9'h101, 9'h1FE,
                  9'h101, 9'h1FF, 9'h02C, 9'h107, 9'h1E0, 9'h107, 9'h1E0,
                  9'h107, 9'h1E0, 9'h107, 9'h1E0};
        cmp_stream("corner", q0, 19);
        check_eq("corner_strobes", strobes, 19);
        check_eq("corner_done", done_cnt, 1);

        // Large panel with a re-pulsed request and a spurious wr_done mid-run.
        inj_step = 200;
        spur_step = 101;
        run_fill(9'd0, 9'd127, 9'd0, 9'd39, 16'h001F, 1, 0, 25000);
        inj_step = -1;
        spur_step = -1;
        exp_q = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h17F, 9'h02B, 9'h100, 9'h100,
                  9'h100, 9'h127, 9'h02C};
        cmp_stream("panel", q0, 11);
        bad_pix = 0;
        for (int i = 11; i < q0.size(); i++) begin
            if (q0[i] !== (((i - 11) % 2 == 0) ? 9'h100 : 9'h11F)) bad_pix++;
        end
        check_eq("panel_bad_pixels", bad_pix, 0);
        check_eq("panel_strobes", strobes, 10251);
        check_eq("panel_done", done_cnt, 1);
        check_eq("panel_busy_gap", busy_gap, 0);

        // Reset after pixel 100 of a 200-pixel row.
        run_fill(9'd0, 9'd199, 9'd0, 9'd0, 16'h1234, 1, 211, 2000);
        check_eq("abort_reached", strobes, 211);
        sys_rst_n = 1'b0;
        resp_cnt = 0;
        step();
        check_eq("abort_data", {23'd0, fill_data}, 32'h000);
        check_eq("abort_en", {31'd0, en_write_fill}, 32'd0);
        check_eq("abort_busy", {31'd0, fill_busy}, 32'd0);
        check_eq("abort_done", {31'd0, fill_done}, 32'd0);
        repeat (3) step();
        sys_rst_n = 1'b1;
        repeat (4) step();
        check_eq("abort_no_done", done_cnt, 0);

        run_fill(9'd5, 9'd5, 9'd7, 9'd7, 16'hF800, 3, 0, 200);
        load_1x1();
        cmp_stream("again", q0, 13);
        check_eq("again_strobes", strobes, 13);
        check_eq("again_done", done_cnt, 1);

        check_eq("dut1_lockstep", desync, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
